// File: rtl/bfm_apb_pkg.sv
// Shared types and constants for the behavioural APB3 completer.
package bfm_apb_pkg;

    localparam int          APB_DW      = 32;
    localparam int          ERR_CNT_MAX = 255;
    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

endpackage

// File: rtl/bfm_apb_slave_if.sv
// APB3 bus between one master PSEL line and one completer.
interface bfm_apb_slave_if;
    import bfm_apb_pkg::*;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PADDR;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_DW-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/bfm_apb_lfsr.sv
// Seeded 16-bit Fibonacci LFSR that steps once per asserted advance strobe;
// exposes the low three bits as the extra wait-state count.
module bfm_apb_lfsr
    import bfm_apb_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    output logic [2:0] extra
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (adv) begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign extra = lfsr_q[2:0];

endmodule

// File: rtl/bfm_apb_slave.sv
// Behavioural APB3 completer: word memory, wait states, PSLVERR decode and a
// master protocol checker. Define BFM_APBSLAVE_RANDWAIT_EN for LFSR-randomised waits.
module bfm_apb_slave
    import bfm_apb_pkg::*;
#(
    parameter int          AWIDTH      = 10,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    bfm_apb_slave_if.slave        bus,
    output logic                  PROT_ERR,
    output logic [7:0]            ERR_CNT
);

    localparam int CNT_W = 5;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || SEED == 16'h0) begin : g_bad_param
        $error("bfm_apb_slave: WAIT_CYCLES must be 0..15 and SEED non-zero");
    end

    logic [APB_DW-1:0] mem [2**AWIDTH];

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       cap_addr;
    logic              cap_write;
    logic [APB_DW-1:0] cap_wdata;
    logic              cap_err;
    logic              pready_q;
    logic              pslverr_q;
    logic [APB_DW-1:0] prdata_q;
    logic              prot_err_q;
    logic [7:0]        err_cnt_q;

    logic              setup_req;
    logic              addr_err;
    logic [AWIDTH-1:0] addr_idx;
    logic [AWIDTH-1:0] cap_idx;
    logic [CNT_W-1:0]  wait_load;
    logic              mem_we;

    assign setup_req = (state == IDLE) && bus.PSEL && !bus.PENABLE;
    assign addr_err  = (bus.PADDR[31:AWIDTH+2] != '0) || (bus.PADDR[1:0] != 2'b00);
    assign addr_idx  = bus.PADDR[AWIDTH+1:2];
    assign cap_idx   = cap_addr[AWIDTH+1:2];

`ifdef BFM_APBSLAVE_RANDWAIT_EN
    logic [2:0] lfsr_extra;

    bfm_apb_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (PCLK),
        .rst_n (PRESETN),
        .adv   (setup_req),
        .extra (lfsr_extra)
    );

    assign wait_load = CNT_W'(WAIT_CYCLES) + {2'b00, lfsr_extra};
`else
    assign wait_load = CNT_W'(WAIT_CYCLES);
`endif

    // pready_q drops asynchronously on reset, so a reset mid-transfer never writes.
    assign mem_we = (state == ACCESS) && bus.PSEL && bus.PENABLE && pready_q
                    && cap_write && !cap_err;

    // NOTE: the memory is deliberately left out of reset; it models RAM and its
    // contents must survive PRESETN, so it lives in its own clock-only process.
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            mem[cap_idx] <= cap_wdata;
        end
    end

    // NOTE: every register here uses non-blocking assignment so all state moves
    // together on the edge regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_addr   <= '0;
            cap_write  <= 1'b0;
            cap_wdata  <= '0;
            cap_err    <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            prot_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup_req) begin
                        cap_addr  <= bus.PADDR;
                        cap_write <= bus.PWRITE;
                        cap_wdata <= bus.PWDATA;
                        cap_err   <= addr_err;
                        cnt       <= wait_load;
                        state     <= ACCESS;
                        if (wait_load == '0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= addr_err;
                            prdata_q  <= (!bus.PWRITE && !addr_err) ? mem[addr_idx] : '0;
                        end
                    end else if (bus.PSEL && bus.PENABLE) begin
                        prot_err_q <= 1'b1;
                    end
                end

                ACCESS: begin
                    if (!bus.PSEL || !bus.PENABLE) begin
                        // Master abandoned the transfer before completion.
                        prot_err_q <= 1'b1;
                        pready_q   <= 1'b0;
                        pslverr_q  <= 1'b0;
                        prdata_q   <= '0;
                        state      <= IDLE;
                    end else begin
                        if (bus.PADDR != cap_addr || bus.PWRITE != cap_write
                            || bus.PWDATA != cap_wdata) begin
                            prot_err_q <= 1'b1;
                        end
                        if (pready_q) begin
                            pready_q  <= 1'b0;
                            pslverr_q <= 1'b0;
                            prdata_q  <= '0;
                            state     <= IDLE;
                            if (cap_err && err_cnt_q != 8'(ERR_CNT_MAX)) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                            if (cnt == CNT_W'(1)) begin
                                pready_q  <= 1'b1;
                                pslverr_q <= cap_err;
                                prdata_q  <= (!cap_write && !cap_err) ? mem[cap_idx] : '0;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.PRDATA  = prdata_q;
    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
    assign PROT_ERR    = prot_err_q;
    assign ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_bfm_apb_slave.sv
// Self-checking bench for bfm_apb_slave: two completers (0 and 3 wait states)
// checked against a transaction-level memory / error / LFSR model.
module tb_bfm_apb_slave;

    localparam int          AW   = 10;
    localparam int          W0   = 0;
    localparam int          W1   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic PCLK = 1'b0;
    logic PRESETN;
    always #5 PCLK = ~PCLK;

    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic        prot_err[2];
    logic [7:0]  err_cnt [2];

    bfm_apb_slave_if bus0 ();
    bfm_apb_slave_if bus1 ();

    assign bus0.PSEL = psel[0];  assign bus0.PENABLE = penable[0];
    assign bus0.PWRITE = pwrite[0];  assign bus0.PADDR = paddr[0];  assign bus0.PWDATA = pwdata[0];
    assign prdata[0] = bus0.PRDATA;  assign pready[0] = bus0.PREADY;  assign pslverr[0] = bus0.PSLVERR;
    assign bus1.PSEL = psel[1];  assign bus1.PENABLE = penable[1];
    assign bus1.PWRITE = pwrite[1];  assign bus1.PADDR = paddr[1];  assign bus1.PWDATA = pwdata[1];
    assign prdata[1] = bus1.PRDATA;  assign pready[1] = bus1.PREADY;  assign pslverr[1] = bus1.PSLVERR;

    bfm_apb_slave #(.AWIDTH(AW), .WAIT_CYCLES(W0), .SEED(SEED)) dut0 (
        .PCLK(PCLK), .PRESETN(PRESETN), .bus(bus0.slave),
        .PROT_ERR(prot_err[0]), .ERR_CNT(err_cnt[0])
    );

    bfm_apb_slave #(.AWIDTH(AW), .WAIT_CYCLES(W1), .SEED(SEED)) dut1 (
        .PCLK(PCLK), .PRESETN(PRESETN), .bus(bus1.slave),
        .PROT_ERR(prot_err[1]), .ERR_CNT(err_cnt[1])
    );

    // Reference model state
    logic [31:0] mem_m  [2][2**AW];
    int          err_m  [2];
    bit          prot_m [2];
    logic [15:0] lfsr_m [2];

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // Extra wait cycles granted to the setup being issued now; advances the model LFSR.
    function automatic int setup_extra(input int d);
        int extra;
        extra = 0;
`ifdef BFM_APBSLAVE_RANDWAIT_EN
        extra = int'(lfsr_m[d][2:0]);
        lfsr_m[d] = lfsr_step(lfsr_m[d]);
`endif
        return extra;
    endfunction

    function automatic int base_wait(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            err_m[d]  = 0;
            prot_m[d] = 1'b0;
            lfsr_m[d] = SEED;
        end
    endtask

    // One full transfer; entered and left just after a rising edge with the bus idle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit glitch);
        int          waits;
        int          exp_wait;
        bit          done;
        bit          exp_err;
        int          idx;
        logic [31:0] exp_rd;
        logic [21:0] hi_bits;

        hi_bits  = addr[31:AW+2];
        exp_err  = (hi_bits != 0) || (addr[1:0] != 2'b00);
        idx      = int'(addr[AW+1:2]);
        exp_rd   = (wr || exp_err) ? 32'h0 : mem_m[d][idx];
        exp_wait = base_wait(d) + setup_extra(d);

        psel[d] = 1'b1;  penable[d] = 1'b0;  pwrite[d] = wr;
        paddr[d] = addr;  pwdata[d] = data;
        @(posedge PCLK); #1;
        penable[d] = 1'b1;
        if (glitch) paddr[d] = addr ^ 32'h4;

        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge PCLK);
            if (pready[d]) begin
                check($sformatf("wait_cycles[%0d] @%h", d, addr), waits, exp_wait);
                check($sformatf("pslverr[%0d] @%h", d, addr), pslverr[d], exp_err);
                check($sformatf("prdata[%0d] @%h", d, addr), prdata[d], exp_rd);
                done = 1'b1;
            end else begin
                waits++;
                check($sformatf("prdata_wait[%0d] @%h", d, addr), prdata[d], 32'h0);
            end
            @(posedge PCLK); #1;
            paddr[d] = addr;
        end
        if (!done) check($sformatf("pready_timeout[%0d] @%h", d, addr), 32'h0, 32'h1);

        psel[d] = 1'b0;  penable[d] = 1'b0;
        if (done && wr && !exp_err) mem_m[d][idx] = data;
        if (done && exp_err && err_m[d] < 255) err_m[d]++;
        if (glitch) prot_m[d] = 1'b1;
        check($sformatf("err_cnt[%0d]", d), err_cnt[d], err_m[d]);
        check($sformatf("prot_err[%0d]", d), prot_err[d], prot_m[d]);
    endtask

    // Start a write, then abandon it after one access cycle (drop PSEL or PENABLE).
    task automatic abort_xfer(input int d, input logic [31:0] addr,
                              input logic [31:0] data, input bit drop_psel);
        void'(setup_extra(d));
        psel[d] = 1'b1;  penable[d] = 1'b0;  pwrite[d] = 1'b1;
        paddr[d] = addr;  pwdata[d] = data;
        @(posedge PCLK); #1;
        penable[d] = 1'b1;
        @(posedge PCLK); #1;
        penable[d] = 1'b0;
        if (drop_psel) psel[d] = 1'b0;
        @(posedge PCLK); #1;
        psel[d] = 1'b0;
        prot_m[d] = 1'b1;
        check($sformatf("abort_prot_err[%0d]", d), prot_err[d], prot_m[d]);
        @(negedge PCLK);
        check($sformatf("abort_pready[%0d]", d), pready[d], 1'b0);
        @(posedge PCLK); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0;  penable[d] = 1'b0;  pwrite[d] = 1'b0;
            paddr[d] = '0;   pwdata[d] = '0;
        end
        model_reset();

        // Reset state
        PRESETN = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_pready[%0d]", d), pready[d], 1'b0);
            check($sformatf("rst_pslverr[%0d]", d), pslverr[d], 1'b0);
            check($sformatf("rst_prdata[%0d]", d), prdata[d], 32'h0);
            check($sformatf("rst_prot_err[%0d]", d), prot_err[d], 1'b0);
            check($sformatf("rst_err_cnt[%0d]", d), err_cnt[d], 8'd0);
        end
        repeat (2) @(posedge PCLK);
        #1 PRESETN = 1'b1;
        @(posedge PCLK); #1;

        // Zero-wait write / read, then three-wait write / read
        xfer(0, 1'b1, 32'h010, 32'hDEADBEEF, 1'b0);
        xfer(0, 1'b0, 32'h010, 32'h0, 1'b0);
        xfer(1, 1'b1, 32'h004, 32'h12345678, 1'b0);
        xfer(1, 1'b0, 32'h004, 32'h0, 1'b0);

        // Randomised legal traffic on word indices 32..47
        for (int i = 0; i < 16; i++) begin
            xfer(0, 1'b1, 32'h80 + 32'(i * 4), $urandom, 1'b0);
            xfer(1, 1'b1, 32'h80 + 32'(i * 4), $urandom, 1'b0);
        end
        for (int i = 0; i < 24; i++) begin
            int          d;
            logic [31:0] a;
            d = int'($urandom_range(1, 0));
            a = 32'h80 + 32'($urandom_range(15, 0) * 4);
            if ($urandom_range(1, 0) == 1) xfer(d, 1'b1, a, $urandom, 1'b0);
            else                           xfer(d, 1'b0, a, 32'h0, 1'b0);
        end

        // Illegal addresses: out of range and misaligned
        xfer(0, 1'b1, 32'h000, 32'hA5A50000, 1'b0);
        xfer(0, 1'b1, 32'h1000, 32'h55, 1'b0);
        xfer(0, 1'b0, 32'h1000, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h002, 32'h0, 1'b0);
        check("err_cnt_after_three", err_cnt[0], 8'd3);
        xfer(0, 1'b0, 32'h000, 32'h0, 1'b0);

        // Protocol violations: access without setup, address change, aborts
        psel[0] = 1'b1;  penable[0] = 1'b1;
        @(posedge PCLK); #1;
        psel[0] = 1'b0;  penable[0] = 1'b0;
        prot_m[0] = 1'b1;
        check("noset_prot_err", prot_err[0], 1'b1);
        xfer(0, 1'b0, 32'h010, 32'h0, 1'b0);

        xfer(1, 1'b1, 32'h84, 32'hCAFEF00D, 1'b1);
        abort_xfer(1, 32'h80, 32'hBADBAD00, 1'b1);
        xfer(1, 1'b0, 32'h80, 32'h0, 1'b0);
        abort_xfer(1, 32'h88, 32'hBADBAD11, 1'b0);
        xfer(1, 1'b0, 32'h88, 32'h0, 1'b0);
        xfer(1, 1'b0, 32'h84, 32'h0, 1'b0);
        check("prot_err_sticky", prot_err[1], 1'b1);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            xfer(0, 1'b0, 32'h1000 + 32'(i % 4), 32'h0, 1'b0);
        end
        check("err_cnt_saturated", err_cnt[0], 8'd255);

        // Reset in the middle of a write to 0x010
        void'(setup_extra(0));
        psel[0] = 1'b1;  penable[0] = 1'b0;  pwrite[0] = 1'b1;
        paddr[0] = 32'h010;  pwdata[0] = 32'hBAD0BAD0;
        @(posedge PCLK); #1;
        penable[0] = 1'b1;
        #2 PRESETN = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midrst_pready[%0d]", d), pready[d], 1'b0);
            check($sformatf("midrst_pslverr[%0d]", d), pslverr[d], 1'b0);
            check($sformatf("midrst_err_cnt[%0d]", d), err_cnt[d], 8'd0);
            check($sformatf("midrst_prot_err[%0d]", d), prot_err[d], 1'b0);
        end
        @(posedge PCLK); #1;
        psel[0] = 1'b0;  penable[0] = 1'b0;
        PRESETN = 1'b1;
        model_reset();
        @(posedge PCLK); #1;
        xfer(0, 1'b0, 32'h010, 32'h0, 1'b0);
        check("retained_0x010", mem_m[0][4], 32'hDEADBEEF);
        xfer(1, 1'b0, 32'h004, 32'h0, 1'b0);

        // Back-to-back reads; wait counts follow the model LFSR when enabled
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                int          w_before;
                logic [15:0] l_before;
                l_before = lfsr_m[d];
                w_before = base_wait(d);
`ifdef BFM_APBSLAVE_RANDWAIT_EN
                w_before = w_before + int'(l_before[2:0]);
`endif
                check($sformatf("wait_range[%0d]", d),
                      32'((w_before >= base_wait(d)) && (w_before <= base_wait(d) + 7)), 32'h1);
                xfer(d, 1'b0, 32'h80 + 32'(i * 4), 32'h0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bfm_apb_slave.md
Name: bfm_apb_slave

Overview:
- Behavioural APB3 completer (slave) for testbenches: the responder at the far end of the APB master BFM's PSEL/PENABLE bus.
- Word-addressed 32-bit memory with programmable wait states and PSLVERR on illegal addresses.
- Sticky protocol-violation flag plus a saturating error counter, so benches can check master behaviour.
- One instance per PSEL line of the master.

Parameters:
AWIDTH, 10, word-address bits; memory depth 2**AWIDTH words
WAIT_CYCLES, 0, PREADY-low cycles inserted in every access phase (0..15)
SEED, 16'hACE1, LFSR seed; used only with the optional feature

Ports:
PCLK  in  1  clock
PRESETN  in  1  reset, asynchronous, active-low
PSEL  in  1  select for this completer
PENABLE  in  1  access-phase strobe
PWRITE  in  1  1=write, 0=read
PADDR  in  32  byte address
PWDATA  in  32  write data
PRDATA  out  32  read data, valid when PREADY=1
PREADY  out  1  transfer-complete strobe (registered)
PSLVERR  out  1  error response, valid when PREADY=1
PROT_ERR  out  1  sticky protocol-violation flag
ERR_CNT  out  8  count of PSLVERR responses, saturates at 255

Behaviour:
- Reset (PRESETN=0, asynchronous): PRDATA=0, PREADY=0, PSLVERR=0, PROT_ERR=0, ERR_CNT=0, FSM=IDLE, wait counter=0. Memory contents are not reset and are retained across reset; benches write a location before reading it.
- Decode: index = PADDR[AWIDTH+1:2]. The address is illegal if PADDR[31:AWIDTH+2]!=0 or PADDR[1:0]!=0.
- FSM states: IDLE, ACCESS.
  - IDLE: on PSEL=1 and PENABLE=0 (setup), capture PADDR/PWRITE/PWDATA. Load cnt=WAIT_CYCLES, set PREADY<=(cnt==0), go to ACCESS.
  - IDLE: PSEL=1 with PENABLE=1 and no prior setup sets PROT_ERR; stay IDLE.
  - ACCESS, PREADY=0: decrement cnt; PREADY<=1 when cnt==1.
  - ACCESS, PSEL&PENABLE&PREADY: the transfer completes at this edge. PREADY<=0, PSLVERR<=0, go to IDLE. A setup presented in the next cycle is accepted (back-to-back transfers, no dead cycle added).
- Latency: with WAIT_CYCLES=N the access phase lasts N+1 cycles, so the transfer takes N+2 cycles including setup.
- Read: PRDATA loads mem[index] on the same edge that raises PREADY; PRDATA=0 in all other cycles.
- Write: mem[index]<=captured PWDATA on the completing edge.
- Error transfer: PSLVERR=1 together with PREADY. A write leaves memory unchanged; a read returns PRDATA=0. ERR_CNT increments on the completing edge and holds at 255.
- Protocol checks during ACCESS, each setting PROT_ERR:
  - PADDR, PWRITE or PWDATA differs from the captured value.
  - PSEL falls before completion (master abort): also no memory update, PREADY<=0, FSM returns to IDLE.
  - PENABLE=0 while PSEL=1 before completion: also no memory update, PREADY<=0, FSM returns to IDLE.
- PROT_ERR clears only on reset.
- Reset asserted mid-transfer: outputs go to reset values immediately; no write occurs.

Optional Feature:
- BFM_APBSLAVE_RANDWAIT_EN defined: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seeded with SEED at reset) advances once per setup phase. Wait count = WAIT_CYCLES + lfsr[2:0], giving 0..7 extra cycles; all other rules are unchanged.
- Undefined: the wait count is exactly WAIT_CYCLES, SEED is unused and no LFSR logic is present.

Decomposition:
- Package bfm_apb_pkg holds: FSM state enum (IDLE, ACCESS), APB_DW=32, the LFSR polynomial tap constant and ERR_CNT_MAX=255.
- One natural sub-module: bfm_apb_lfsr (seeded 16-bit LFSR with an advance enable), instantiated only under BFM_APBSLAVE_RANDWAIT_EN.
- Memory, decode, FSM and checker stay in bfm_apb_slave.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to 0x010, then read 0x010 -> each transfer has one access cycle with PREADY=1; PRDATA=0xDEADBEEF; PSLVERR=0.
- WAIT_CYCLES=3: read 0x004 after writing 0x12345678 -> PREADY low for 3 access cycles, high on the 4th; PRDATA=0x12345678 only in that cycle.
- AWIDTH=10: write 0x55 to 0x1000, then read 0x1000 and 0x002 -> PSLVERR=1 on each of the 3 transfers; read data=0; ERR_CNT=3; memory at index 0 unchanged.
- PADDR changed mid-access, PSEL dropped while WAIT_CYCLES=2 -> PROT_ERR=1 and stays 1; the aborted write leaves memory untouched; a following legal transfer completes normally.
- 260 illegal reads -> ERR_CNT=255; PRESETN pulsed mid-transfer -> PREADY/PSLVERR/ERR_CNT/PROT_ERR=0 immediately, and a readback of 0x010 still returns 0xDEADBEEF.
- Macro defined, SEED=16'hACE1, 16 back-to-back reads -> the wait sequence matches the reference LFSR model, every wait is in the range WAIT_CYCLES..WAIT_CYCLES+7, and the data is correct.
